// File: rtl/c3lib_sync_filt_edge_det.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | c3lib_sync_filt_edge_det                                                 |
// | Glitch filter, edge pulse generator and saturating transition counter    |
// | for an already-synchronized level.                                       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module c3lib_sync_filt_edge_det #(
  parameter int unsigned FILTER_CYCLES = 4,
  parameter int unsigned CNT_WIDTH     = 8,
  parameter bit          RESET_VAL     = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 data_in,
  input  logic                 cnt_clr,
  output logic                 data_out,
  output logic                 rise_pls,
  output logic                 fall_pls,
  output logic                 filt_busy,
  output logic [CNT_WIDTH-1:0] edge_cnt
);

  localparam int unsigned          C_QW       = $clog2(FILTER_CYCLES + 1);
  localparam logic [C_QW-1:0]      C_QLAST    = C_QW'(FILTER_CYCLES - 1);
  localparam logic [C_QW-1:0]      C_QONE     = C_QW'(1);
  localparam bit                   C_NO_FILT  = (FILTER_CYCLES == 1);
  localparam logic [CNT_WIDTH-1:0] C_CNT_MAX  = '1;
  localparam logic [CNT_WIDTH-1:0] C_CNT_ONE  = CNT_WIDTH'(1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_CHECK = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [C_QW-1:0]        qcnt_q, qcnt_d;
  logic                   data_q, data_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   w_diff;
  logic                   w_toggle;

  assign w_diff = (data_in != data_q);

  always_comb begin
    state_d  = state_q;
    qcnt_d   = qcnt_q;
    w_toggle = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!w_diff) begin
          qcnt_d = '0;
        end else if (C_NO_FILT) begin
          w_toggle = 1'b1;
          qcnt_d   = '0;
        end else begin
          qcnt_d  = C_QONE;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (!w_diff) begin
          // Input fell back before qualifying: treat as a glitch.
          qcnt_d  = '0;
          state_d = S_IDLE;
        end else if (qcnt_q == C_QLAST) begin
          w_toggle = 1'b1;
          qcnt_d   = '0;
          state_d  = S_IDLE;
        end else begin
          qcnt_d = qcnt_q + C_QONE;
        end
      end
      default: begin
        qcnt_d  = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    data_d = w_toggle ? ~data_q : data_q;
    rise_d = w_toggle & ~data_q;
    fall_d = w_toggle &  data_q;
    cnt_d  = cnt_q;
    if (w_toggle) begin
      // A clear coinciding with a transition still counts that transition.
      if (cnt_clr) begin
        cnt_d = C_CNT_ONE;
      end else if (cnt_q != C_CNT_MAX) begin
        cnt_d = cnt_q + C_CNT_ONE;
      end
    end else if (cnt_clr) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      qcnt_q  <= '0;
      data_q  <= RESET_VAL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      qcnt_q  <= qcnt_d;
      data_q  <= data_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      cnt_q   <= cnt_d;
    end
  end

  assign data_out  = data_q;
  assign rise_pls  = rise_q;
  assign fall_pls  = fall_q;
  assign filt_busy = (state_q == S_CHECK);
  assign edge_cnt  = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_c3lib_sync_filt_edge_det.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_c3lib_sync_filt_edge_det                                              |
// | Scoreboard bench: a run-length reference model queues expected outputs.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_c3lib_sync_filt_edge_det;

  localparam int unsigned FC  = 4;
  localparam int unsigned CW  = 2;
  localparam bit          RV  = 1'b0;
  localparam int          CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          data_in = 1'b0;
  logic          cnt_clr = 1'b0;
  logic          data_out;
  logic          rise_pls;
  logic          fall_pls;
  logic          filt_busy;
  logic [CW-1:0] edge_cnt;

  typedef struct {
    logic dout;
    logic rise;
    logic fall;
    logic busy;
    int   cnt;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  logic m_lvl = RV;
  int   m_run = 0;
  int   m_cnt = 0;

  c3lib_sync_filt_edge_det #(
    .FILTER_CYCLES (FC),
    .CNT_WIDTH     (CW),
    .RESET_VAL     (RV)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .data_in   (data_in),
    .cnt_clr   (cnt_clr),
    .data_out  (data_out),
    .rise_pls  (rise_pls),
    .fall_pls  (fall_pls),
    .filt_busy (filt_busy),
    .edge_cnt  (edge_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: count consecutive samples differing from the level; flip at FC.
  task automatic step(input logic rn, input logic din, input logic clr);
    exp_t e;
    logic tog;
    rst_n   = rn;
    data_in = din;
    cnt_clr = clr;
    tog     = 1'b0;
    if (!rn) begin
      m_lvl = RV;
      m_run = 0;
      m_cnt = 0;
    end else begin
      if (din !== m_lvl) m_run++;
      else               m_run = 0;
      if (m_run == FC) begin
        tog   = 1'b1;
        m_run = 0;
      end
      if (tog)      m_cnt = clr ? 1 : ((m_cnt == CMAX) ? CMAX : m_cnt + 1);
      else if (clr) m_cnt = 0;
    end
    e.rise = tog & ~m_lvl;
    e.fall = tog &  m_lvl;
    if (tog) m_lvl = ~m_lvl;
    e.dout = m_lvl;
    e.busy = (m_run != 0);
    e.cnt  = m_cnt;
    q.push_back(e);
    @(posedge clk);
    #1;
    e = q.pop_front();
    check_val("data_out",  32'(data_out),  32'(e.dout));
    check_val("rise_pls",  32'(rise_pls),  32'(e.rise));
    check_val("fall_pls",  32'(fall_pls),  32'(e.fall));
    check_val("filt_busy", 32'(filt_busy), 32'(e.busy));
    check_val("edge_cnt",  32'(edge_cnt),  32'(e.cnt));
  endtask

  // Hold a level for a full qualification, optionally clearing on the toggle edge.
  task automatic qualify(input logic val, input logic clr_last);
    for (int i = 0; i < FC; i++) step(1'b1, val, clr_last && (i == FC - 1));
    step(1'b1, val, 1'b0);
  endtask

  initial begin
    int first_hi;

    // Reset with a toggling and unknown input.
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'bx, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);

    // Glitch: three high samples only.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
    check_val("glitch_lvl", 32'(data_out), 32'd0);
    check_val("glitch_cnt", 32'(edge_cnt), 32'd0);

    // Clean rise: busy for three cycles, level and pulse after the fourth.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b0);
      check_val("rise_busy", 32'(filt_busy), 32'd1);
    end
    step(1'b1, 1'b1, 1'b0);
    check_val("rise_pulse", 32'(rise_pls), 32'd1);
    check_val("rise_cnt",   32'(edge_cnt), 32'd1);
    step(1'b1, 1'b1, 1'b0);
    check_val("rise_once",  32'(rise_pls), 32'd0);

    // Saturation: five more transitions (six total) -> 2,3,3,3,3.
    for (int t = 0; t < 5; t++) qualify(t[0] ? 1'b1 : 1'b0, 1'b0);
    check_val("sat_cnt", 32'(edge_cnt), 32'(CMAX));

    // Another rise, plain clear, then build to 2 and collide clear with a fall.
    qualify(1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    check_val("clr_cnt", 32'(edge_cnt), 32'd0);
    qualify(1'b0, 1'b0);
    qualify(1'b1, 1'b0);
    check_val("pre_coll_cnt", 32'(edge_cnt), 32'd2);
    for (int i = 0; i < FC; i++) step(1'b1, 1'b0, i == FC - 1);
    check_val("coll_fall", 32'(fall_pls), 32'd1);
    check_val("coll_cnt",  32'(edge_cnt), 32'd1);
    step(1'b1, 1'b0, 1'b0);

    // Reset on the third qualifying cycle, then a full restart.
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    check_val("rst_mid_lvl",  32'(data_out),  32'(RV));
    check_val("rst_mid_busy", 32'(filt_busy), 32'd0);
    first_hi = 0;
    for (int i = 1; i <= 6; i++) begin
      step(1'b1, 1'b1, 1'b0);
      if (first_hi == 0 && data_out) first_hi = i;
    end
    check_val("restart_lat", 32'(first_hi), 32'(FC));
    check_val("sb_empty",    32'(q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/c3lib_sync_filt_edge_det.md
Name: c3lib_sync_filt_edge_det

Overview:
- Consumes the output of a 2-stage reset-clear synchronizer. The input is already in the clk domain; this block adds no metastability flops.
- Rejects glitches shorter than FILTER_CYCLES on that input and produces a filtered level.
- Generates single-cycle rise and fall pulses on filtered level changes.
- Keeps a saturating count of filtered transitions for status/debug readout.
- Sits between a c3lib sync primitive and control logic that needs clean pulses (e.g. AIB handshake and adapter-reset request paths).

Parameters:
- FILTER_CYCLES, 4, consecutive cycles the input must differ from the filtered level before the level updates; legal range 1..255.
- CNT_WIDTH, 8, width of the transition counter; legal range 1..16.
- RESET_VAL, 0, reset value of the filtered level; must match the RESET_VAL of the upstream synchronizer.

Ports:
- clk  input  1  block clock; same clock as the upstream synchronizer.
- rst_n  input  1  reset, synchronous, active-low; sampled on clk rising edge.
- data_in  input  1  synchronized level from the upstream sync stage.
- cnt_clr  input  1  synchronous clear of edge_cnt.
- data_out  output  1  filtered level.
- rise_pls  output  1  one-cycle pulse on filtered 0->1.
- fall_pls  output  1  one-cycle pulse on filtered 1->0.
- filt_busy  output  1  high while a candidate change is being qualified (state CHECK).
- edge_cnt  output  CNT_WIDTH  saturating count of filtered transitions.

Behaviour:
- Interface fixed: one clock clk; rst_n is synchronous, active-low. No asynchronous elements.
- Reset, on any clk edge with rst_n=0:
  - data_out=RESET_VAL, rise_pls=0, fall_pls=0, filt_busy=0, edge_cnt=0.
  - Qualification counter=0, state=IDLE.
  - Reset overrides all other activity, including mid-CHECK; the pending change is discarded.
- Qualification counter: width $clog2(FILTER_CYCLES+1), internal.
- FSM, two states: IDLE, CHECK.
  - IDLE, data_in==data_out: stay IDLE, counter=0.
  - IDLE, data_in!=data_out, FILTER_CYCLES==1: toggle data_out at this edge; stay IDLE.
  - IDLE, data_in!=data_out, FILTER_CYCLES>1: counter=1, go CHECK.
  - CHECK, data_in==data_out (glitch): counter=0, return to IDLE; data_out unchanged; no pulse.
  - CHECK, data_in!=data_out, counter<FILTER_CYCLES-1: counter+1, stay CHECK.
  - CHECK, data_in!=data_out, counter==FILTER_CYCLES-1: toggle data_out, counter=0, return to IDLE.
- filt_busy=1 exactly when state==CHECK. Registered; no combinational input-to-output paths.
- Latency: data_in first differs at sampling edge k -> data_out changes at edge k+FILTER_CYCLES-1, visible the following cycle.
- Pulses: rise_pls/fall_pls are registered alongside data_out and are high for exactly the one cycle in which data_out first shows the new value. They are never both high. Back-to-back transitions are impossible for FILTER_CYCLES>1.
- edge_cnt update, per cycle:
  - cnt_clr=1 and no toggle: edge_cnt=0.
  - cnt_clr=1 and toggle in the same cycle: edge_cnt=1 (the transition is counted after the clear).
  - cnt_clr=0 and toggle: edge_cnt+1, saturating at 2^CNT_WIDTH-1. No wrap.
  - otherwise: hold.
- Input X during reset must not propagate; the next state is fully determined by reset.

Test Plan:
- Reset: rst_n=0 for 3 cycles with data_in toggling -> data_out=0, pulses=0, filt_busy=0, edge_cnt=0 throughout. Release -> same values.
- Clean rise, FILTER_CYCLES=4: data_in 0->1 sampled at edge 10 and held -> filt_busy high at edges 10-12, data_out=1 and rise_pls=1 after edge 13 for one cycle, edge_cnt=1.
- Glitch reject, FILTER_CYCLES=4: data_in high for 3 cycles then low -> data_out stays 0, no pulses, edge_cnt=0, filt_busy returns to 0.
- Saturation, CNT_WIDTH=2: six qualified toggles -> edge_cnt sequence 1,2,3,3,3,3. Rise and fall pulses alternate.
- Clear collision: cnt_clr=1 in the same cycle a fall is qualified with edge_cnt=2 -> edge_cnt=1, fall_pls=1.
- Reset mid-CHECK: rst_n=0 on the 3rd qualifying cycle -> data_out=RESET_VAL, no pulse. After release with data_in still 1 -> full 4-cycle qualification restarts from zero.
